// File: rtl/dram_pkg.sv
// dram_pkg: shared FSM, configuration and default AXI types for the DRAM transaction gate
package dram_pkg;
  localparam int unsigned AxiIdWidth = 6;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;
  typedef enum logic [1:0] {WAIT_CALIB, RUN, DRAIN} dram_gate_state_e;
  typedef struct packed {
    int unsigned id_width;
    int unsigned max_reads;
    int unsigned max_writes;
  } dram_gate_cfg_t;
  localparam dram_gate_cfg_t DefaultGateCfg = '{id_width: AxiIdWidth, max_reads: 8, max_writes: 8};
  typedef logic [AxiIdWidth-1:0] axi_id_t;
  typedef struct packed {
    axi_id_t id;
    logic [AddrWidth-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [UserWidth-1:0] user;
  } axi_ax_chan_t;
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [DataWidth/8-1:0] strb;
    logic last;
    logic [UserWidth-1:0] user;
  } axi_w_chan_t;
  typedef struct packed {
    axi_id_t id;
    logic [1:0] resp;
    logic [UserWidth-1:0] user;
  } axi_b_chan_t;
  typedef struct packed {
    axi_id_t id;
    logic [DataWidth-1:0] data;
    logic [1:0] resp;
    logic last;
    logic [UserWidth-1:0] user;
  } axi_r_chan_t;
  typedef struct packed {
    axi_ax_chan_t aw;
    logic aw_valid;
    axi_w_chan_t w;
    logic w_valid;
    logic b_ready;
    axi_ax_chan_t ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    axi_b_chan_t b;
    logic r_valid;
    axi_r_chan_t r;
  } axi_resp_t;
endpackage

// File: rtl/dram_txn_gate_fifo.sv
// dram_txn_gate_fifo: ID FIFO whose head is read straight from storage, visible the cycle after push
module dram_txn_gate_fifo #(
  parameter int unsigned Width = 6,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign data_o = mem_q[rptr_q[PtrW-1:0]];
  always_comb begin
    mem_d = mem_q;
    wptr_d = push_i ? wptr_q + (PtrW+1)'(1) : wptr_q;
    rptr_d = pop_i ? rptr_q + (PtrW+1)'(1) : rptr_q;
    if (push_i) mem_d[wptr_q[PtrW-1:0]] = data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/dram_txn_gate.sv
// dram_txn_gate: calibration-gated AXI scheduler that zeroes downstream IDs and restores them in order
module dram_txn_gate
  import dram_pkg::*;
#(
  parameter type axi_req_t = dram_pkg::axi_req_t,
  parameter type axi_resp_t = dram_pkg::axi_resp_t,
  parameter int unsigned IdWidth = DefaultGateCfg.id_width,
  parameter int unsigned MaxReads = DefaultGateCfg.max_reads,
  parameter int unsigned MaxWrites = DefaultGateCfg.max_writes
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      calib_done_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_rsp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_rsp_i,
  output logic      busy_o
);
  localparam int unsigned WpW = $clog2(MaxWrites) + 1;
  dram_gate_state_e state_q, state_d;
  logic [WpW-1:0] wpend_q, wpend_d;
  logic [IdWidth-1:0] rd_head, wr_head;
  logic rd_empty, rd_full, wr_empty, wr_full;
  logic ar_ok, aw_ok, w_ok, ar_hs, aw_hs, w_last_hs, r_pop, b_pop, drained;
  // gating uses only registered state, so no ready-to-valid path is added
  assign ar_ok = state_q == RUN && !rd_full;
  assign aw_ok = state_q == RUN && !wr_full;
  assign w_ok = state_q == RUN || (state_q == DRAIN && wpend_q != '0);
  assign ar_hs = ar_ok && slv_req_i.ar_valid && mst_rsp_i.ar_ready;
  assign aw_hs = aw_ok && slv_req_i.aw_valid && mst_rsp_i.aw_ready;
  assign w_last_hs = w_ok && slv_req_i.w_valid && mst_rsp_i.w_ready && slv_req_i.w.last;
  assign r_pop = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last && !rd_empty;
  assign b_pop = mst_rsp_i.b_valid && slv_req_i.b_ready && !wr_empty;
  assign drained = rd_empty && wr_empty && wpend_q == '0;
  assign busy_o = !drained;
  always_comb begin
    mst_req_o = slv_req_i;
    mst_req_o.ar.id = '0;
    mst_req_o.aw.id = '0;
    mst_req_o.ar_valid = slv_req_i.ar_valid && ar_ok;
    mst_req_o.aw_valid = slv_req_i.aw_valid && aw_ok;
    mst_req_o.w_valid = slv_req_i.w_valid && w_ok;
    slv_rsp_o = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_ok;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_ok;
    slv_rsp_o.w_ready = mst_rsp_i.w_ready && w_ok;
    slv_rsp_o.r.id = rd_empty ? '0 : rd_head;
    slv_rsp_o.b.id = wr_empty ? '0 : wr_head;
    slv_rsp_o.r.user = '0;
    slv_rsp_o.b.user = '0;
  end
  always_comb begin
    wpend_d = wpend_q + WpW'(aw_hs) - WpW'(w_last_hs);
    state_d = state_q == WAIT_CALIB ? (calib_done_i ? RUN : WAIT_CALIB)
            : state_q == RUN        ? (calib_done_i ? RUN : DRAIN)
            : calib_done_i          ? RUN
            : drained               ? WAIT_CALIB : DRAIN;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_CALIB;
      wpend_q <= '0;
    end else begin
      state_q <= state_d;
      wpend_q <= wpend_d;
    end
  end
  dram_txn_gate_fifo #(.Width(IdWidth), .Depth(MaxReads)) i_rd_ids (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ar_hs),
    .data_i  (slv_req_i.ar.id),
    .pop_i   (r_pop),
    .data_o  (rd_head),
    .empty_o (rd_empty),
    .full_o  (rd_full)
  );
  dram_txn_gate_fifo #(.Width(IdWidth), .Depth(MaxWrites)) i_wr_ids (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .data_i  (slv_req_i.aw.id),
    .pop_i   (b_pop),
    .data_o  (wr_head),
    .empty_o (wr_empty),
    .full_o  (wr_full)
  );
  // a response with nothing outstanding means the controller broke protocol
  assert property (@(posedge clk_i) disable iff (!rst_ni) mst_rsp_i.r_valid |-> !rd_empty);
  assert property (@(posedge clk_i) disable iff (!rst_ni) mst_rsp_i.b_valid |-> !wr_empty);
endmodule

// File: tb/tb_dram_txn_gate.sv
// tb_dram_txn_gate: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_dram_txn_gate;
  import dram_pkg::*;
  logic clk = 0, rst_n = 1, calib = 0, busy;
  axi_req_t req, mst_req;
  axi_resp_t mst_rsp, slv_rsp;
  int tests = 0, fails = 0;
  logic [31:0] exp_ar_addr[$], exp_aw_addr[$];
  logic [5:0] exp_r_id[$], exp_b_id[$];

  dram_txn_gate dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .calib_done_i (calib),
    .slv_req_i    (req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic unexpected(input string n);
    tests++;
    fails++;
    $display("FAIL %s: got handshake expected none queued", n);
  endtask

  // monitor: pops the scoreboard whenever the DUT completes a transfer
  always @(negedge clk) if (rst_n) begin
    if (mst_req.ar_valid && mst_rsp.ar_ready) begin
      check("ar_down_id", 64'(mst_req.ar.id), 0);
      if (exp_ar_addr.size() == 0) unexpected("ar_extra");
      else check("ar_addr", 64'(mst_req.ar.addr), 64'(exp_ar_addr.pop_front()));
    end
    if (mst_req.aw_valid && mst_rsp.aw_ready) begin
      check("aw_down_id", 64'(mst_req.aw.id), 0);
      if (exp_aw_addr.size() == 0) unexpected("aw_extra");
      else check("aw_addr", 64'(mst_req.aw.addr), 64'(exp_aw_addr.pop_front()));
    end
    if (slv_rsp.r_valid && req.r_ready && slv_rsp.r.last) begin
      check("r_user", 64'(slv_rsp.r.user), 0);
      if (exp_r_id.size() == 0) unexpected("r_extra");
      else check("r_id", 64'(slv_rsp.r.id), 64'(exp_r_id.pop_front()));
    end
    if (slv_rsp.b_valid && req.b_ready) begin
      check("b_user", 64'(slv_rsp.b.user), 0);
      if (exp_b_id.size() == 0) unexpected("b_extra");
      else check("b_id", 64'(slv_rsp.b.id), 64'(exp_b_id.pop_front()));
    end
  end

  task automatic send_ar(input logic [5:0] id, input logic [31:0] addr);
    int n = 0;
    exp_ar_addr.push_back(addr);
    exp_r_id.push_back(id);
    req.ar.id = id;
    req.ar.addr = addr;
    req.ar_valid = 1;
    do begin @(negedge clk); n++; end while (!slv_rsp.ar_ready && n < 50);
    check("ar_accept", 64'(slv_rsp.ar_ready), 1);
    @(posedge clk); #1;
    req.ar_valid = 0;
  endtask

  task automatic send_aw(input logic [5:0] id, input logic [31:0] addr);
    int n = 0;
    exp_aw_addr.push_back(addr);
    exp_b_id.push_back(id);
    req.aw.id = id;
    req.aw.addr = addr;
    req.aw_valid = 1;
    do begin @(negedge clk); n++; end while (!slv_rsp.aw_ready && n < 50);
    check("aw_accept", 64'(slv_rsp.aw_ready), 1);
    @(posedge clk); #1;
    req.aw_valid = 0;
  endtask

  task automatic send_w(input logic last, input string n);
    req.w.last = last;
    req.w.data = 64'hcafe_0000 + 64'(last);
    req.w_valid = 1;
    @(negedge clk);
    check(n, 64'(slv_rsp.w_ready), 1);
    @(posedge clk); #1;
    req.w_valid = 0;
  endtask

  task automatic send_r();
    mst_rsp.r_valid = 1;
    mst_rsp.r.last = 1;
    mst_rsp.r.user = 1;
    @(posedge clk); #1;
    mst_rsp.r_valid = 0;
  endtask

  task automatic send_b();
    mst_rsp.b_valid = 1;
    mst_rsp.b.user = 1;
    @(posedge clk); #1;
    mst_rsp.b_valid = 0;
  endtask

  initial begin
    int viol;
    req = '0;
    mst_rsp = '0;
    req.r_ready = 1;
    req.b_ready = 1;
    mst_rsp.ar_ready = 1;
    mst_rsp.aw_ready = 1;
    mst_rsp.w_ready = 1;
    #2 rst_n = 0;
    req.ar_valid = 1;
    req.ar.id = 5;
    req.ar.addr = 32'h100;
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_ar_ready", 64'(slv_rsp.ar_ready), 0);
    check("rst_aw_ready", 64'(slv_rsp.aw_ready), 0);
    check("rst_w_ready", 64'(slv_rsp.w_ready), 0);
    check("rst_mst_ar_valid", 64'(mst_req.ar_valid), 0);
    @(posedge clk); #1;
    rst_n = 1;
    // calibration hold: AR id 5 must wait
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (slv_rsp.ar_ready || mst_req.ar_valid) viol++;
    end
    check("calib_hold", 64'(viol), 0);
    @(posedge clk); #1;
    calib = 1;
    send_ar(6'd5, 32'h100);
    send_r();
    // in-order ID restoration
    send_ar(6'd3, 32'h200);
    send_ar(6'd17, 32'h240);
    send_ar(6'd42, 32'h280);
    repeat (3) send_r();
    // capacity: 8 outstanding, 9th waits for first R-last
    for (int i = 0; i < 8; i++) send_ar(6'(10 + i), 32'h1000 + 32'(i * 64));
    exp_ar_addr.push_back(32'h2000);
    exp_r_id.push_back(6'd18);
    req.ar.id = 18;
    req.ar.addr = 32'h2000;
    req.ar_valid = 1;
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (slv_rsp.ar_ready) viol++;
    end
    check("ar_full_stall", 64'(viol), 0);
    check("busy_reads", 64'(busy), 1);
    @(posedge clk); #1;
    mst_rsp.r_valid = 1;
    mst_rsp.r.last = 1;
    @(negedge clk);
    check("ar_full_pop_cycle", 64'(slv_rsp.ar_ready), 0);
    @(posedge clk); #1;
    mst_rsp.r_valid = 0;
    @(negedge clk);
    check("ar_after_pop", 64'(slv_rsp.ar_ready), 1);
    @(posedge clk); #1;
    req.ar_valid = 0;
    repeat (8) send_r();
    @(negedge clk);
    check("busy_reads_done", 64'(busy), 0);
    @(posedge clk); #1;
    // W ahead of AW
    send_w(0, "w_early_0");
    send_w(1, "w_early_1");
    send_aw(6'd33, 32'h3000);
    send_b();
    @(negedge clk);
    check("busy_after_b", 64'(busy), 0);
    @(posedge clk); #1;
    // drain: AW outstanding when calibration drops
    send_aw(6'd21, 32'h4000);
    calib = 0;
    @(posedge clk); #1;
    req.ar.id = 7;
    req.ar_valid = 1;
    req.aw.id = 8;
    req.aw_valid = 1;
    @(negedge clk);
    check("drain_ar_block", 64'(slv_rsp.ar_ready), 0);
    check("drain_aw_block", 64'(slv_rsp.aw_ready), 0);
    check("drain_mst_ar", 64'(mst_req.ar_valid), 0);
    check("drain_busy", 64'(busy), 1);
    @(posedge clk); #1;
    send_w(0, "drain_w0");
    send_w(1, "drain_w1");
    req.w_valid = 1;
    @(negedge clk);
    check("drain_w_block", 64'(slv_rsp.w_ready), 0);
    @(posedge clk); #1;
    req.w_valid = 0;
    send_b();
    @(posedge clk);
    @(negedge clk);
    check("drain_to_wait", 64'(dut.state_q), 64'(WAIT_CALIB));
    check("wait_ar_block", 64'(slv_rsp.ar_ready), 0);
    check("wait_busy", 64'(busy), 0);
    @(posedge clk); #1;
    req.ar_valid = 0;
    req.aw_valid = 0;
    // reset with 4 reads outstanding
    calib = 1;
    for (int i = 0; i < 4; i++) send_ar(6'(50 + i), 32'h5000 + 32'(i * 64));
    @(negedge clk);
    check("busy_4rd", 64'(busy), 1);
    @(posedge clk); #1;
    rst_n = 0;
    req.ar_valid = 1;
    req.w_valid = 1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_ar_ready", 64'(slv_rsp.ar_ready), 0);
    check("midrst_w_ready", 64'(slv_rsp.w_ready), 0);
    check("midrst_mst_ar", 64'(mst_req.ar_valid), 0);
    @(posedge clk); #1;
    req.ar_valid = 0;
    req.w_valid = 0;
    exp_r_id.delete();
    rst_n = 1;
    @(negedge clk);
    check("postrst_busy", 64'(busy), 0);
    check("sb_left", 64'(exp_ar_addr.size() + exp_aw_addr.size() + exp_b_id.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
